// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU VRAM arbiter and its address register.
package ppu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACCESS,
    CAPTURE
  } arb_state_t;

  localparam logic [13:0] INC1  = 14'd1;
  localparam logic [13:0] INC32 = 14'd32;

  // VRAM address space is 14 bits wide, so the step wraps naturally.
  function automatic logic [13:0] next_vaddr(input logic [13:0] a, input logic sel32);
    return a + (sel32 ? INC32 : INC1);
  endfunction

endpackage

// File: rtl/ppu_vaddr_reg.sv
// CPU-visible VRAM address register: two-write latch (high byte first) plus
// post-access increment. A CPU address write takes priority over the increment.
module ppu_vaddr_reg
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        addr_wr,
  input  logic [7:0]  wdata,
  input  logic        inc,
  input  logic        inc32,
  output logic [15:0] addr
);

  logic        w;
  logic [13:0] a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w <= 1'b0;
      a <= '0;
    end else if (addr_wr) begin
      if (!w) a[13:8] <= wdata[5:0];
      else    a[7:0]  <= wdata;
      w <= ~w;
    end else if (inc) begin
      a <= next_vaddr(a, inc32);
    end
  end

  assign addr = {2'b00, a};

endmodule

// File: rtl/ppu_vram_arb.sv
// Arbitrates the VRAM port between the scanline renderer and CPU data-register
// accesses; CPU accesses wait until rendering stops, reads are one-deep buffered.
module ppu_vram_arb
  import ppu_pkg::*;
#(
  parameter int VIS_LINES = 240,
  parameter int PRE_LINE  = 261
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        render_en,
  input  logic [9:0]  scanline,
  input  logic [15:0] render_addr,
  input  logic        cpu_addr_wr,
  input  logic        cpu_data_wr,
  input  logic        cpu_data_rd,
  input  logic [7:0]  cpu_wdata,
  input  logic        inc32,
  input  logic [7:0]  vram_rdata,
  output logic [15:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        busy,
  output logic        overrun
);

  arb_state_t  state, next_state;
  logic        rendering;
  logic        cpu_req;
  logic        acc_wr;
  logic [15:0] acc_addr;
  logic [7:0]  acc_data;
  logic [7:0]  read_buf;
  logic [15:0] addr;

  assign rendering = render_en &&
                     ((scanline < 10'(VIS_LINES)) || (scanline == 10'(PRE_LINE)));
  assign cpu_req   = cpu_data_rd | cpu_data_wr;

  ppu_vaddr_reg u_vaddr (
    .clk     (clk),
    .reset   (reset),
    .addr_wr (cpu_addr_wr),
    .wdata   (cpu_wdata),
    .inc     (state == ACCESS),
    .inc32   (inc32),
    .addr    (addr)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cpu_req) next_state = PEND;
      PEND:    if (!rendering) next_state = ACCESS;
      ACCESS:  next_state = acc_wr ? IDLE : CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Requests arriving while an access is outstanding are dropped and flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc_wr   <= 1'b0;
      acc_addr <= '0;
      acc_data <= '0;
      read_buf <= '0;
      overrun  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && cpu_req) begin
        acc_wr   <= cpu_data_wr;
        acc_addr <= addr;
        acc_data <= cpu_wdata;
      end
      if (state == CAPTURE) read_buf <= vram_rdata;
      if (state != IDLE && cpu_req) overrun <= 1'b1;
    end
  end

  assign vram_addr  = (state == ACCESS) ? acc_addr : render_addr;
  assign vram_we    = (state == ACCESS) && acc_wr;
  assign vram_wdata = acc_data;
  assign cpu_rdata  = read_buf;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Randomised and directed bench for ppu_vram_arb against a transaction-level model.
module tb_ppu_vram_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        render_en = 1'b0;
  logic [9:0]  scanline = '0;
  logic [15:0] render_addr = '0;
  logic        cpu_addr_wr = 1'b0;
  logic        cpu_data_wr = 1'b0;
  logic        cpu_data_rd = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic        inc32 = 1'b0;
  logic [7:0]  vram_rdata = '0;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  cpu_rdata;
  logic        busy;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] vram  [0:16383];
  logic [7:0] mvram [0:16383];

  // Model state: a single outstanding CPU transaction plus the address register.
  int         m_addr;
  bit         m_w;
  bit         t_valid, t_hold, t_is_wr;
  int         t_age;
  int         t_addr;
  logic [7:0] m_wdata, m_buf;
  bit         m_ovr;

  always #5 clk = ~clk;

  ppu_vram_arb dut (
    .clk         (clk),
    .reset       (reset),
    .render_en   (render_en),
    .scanline    (scanline),
    .render_addr (render_addr),
    .cpu_addr_wr (cpu_addr_wr),
    .cpu_data_wr (cpu_data_wr),
    .cpu_data_rd (cpu_data_rd),
    .cpu_wdata   (cpu_wdata),
    .inc32       (inc32),
    .vram_rdata  (vram_rdata),
    .vram_addr   (vram_addr),
    .vram_we     (vram_we),
    .vram_wdata  (vram_wdata),
    .cpu_rdata   (cpu_rdata),
    .busy        (busy),
    .overrun     (overrun)
  );

  always @(posedge clk) begin
    vram_rdata <= vram[vram_addr[13:0]];
    if (vram_we) vram[vram_addr[13:0]] <= vram_wdata;
  end

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    bit rend, incr;
    if (!reset) begin
      m_addr = 0; m_w = 0; t_valid = 0; t_hold = 0; t_is_wr = 0;
      t_age = 0; t_addr = 0; m_wdata = '0; m_buf = '0; m_ovr = 0;
    end else begin
      rend = render_en && (scanline < 240 || scanline == 261);
      incr = 0;
      if (!t_valid) begin
        if (cpu_data_rd || cpu_data_wr) begin
          t_valid = 1; t_hold = 1; t_is_wr = cpu_data_wr;
          t_addr = m_addr; m_wdata = cpu_wdata;
        end
      end else begin
        if (cpu_data_rd || cpu_data_wr) m_ovr = 1;
        if (t_hold) begin
          if (!rend) begin t_hold = 0; t_age = 0; end
        end else if (t_age == 0) begin
          incr = 1;
          if (t_is_wr) begin mvram[t_addr] = m_wdata; t_valid = 0; end
          else t_age = 1;
        end else begin
          m_buf = mvram[t_addr];
          t_valid = 0;
        end
      end
      if (cpu_addr_wr) begin
        if (!m_w) m_addr = (m_addr & 'hFF) | ((int'(cpu_wdata) & 'h3F) << 8);
        else      m_addr = (m_addr & 'h3F00) | int'(cpu_wdata);
        m_w = !m_w;
      end else if (incr) begin
        m_addr = (m_addr + (inc32 ? 32 : 1)) % 16384;
      end
    end
  end

  always @(posedge clk) begin
    bit issue;
    #1;
    issue = t_valid && !t_hold && t_age == 0;
    check_output("vram_addr",  vram_addr,  issue ? 16'(t_addr) : render_addr);
    check_output("vram_we",    16'(vram_we), 16'(issue && t_is_wr));
    check_output("vram_wdata", 16'(vram_wdata), 16'(m_wdata));
    check_output("cpu_rdata",  16'(cpu_rdata), 16'(m_buf));
    check_output("busy",       16'(busy), 16'(t_valid));
    check_output("overrun",    16'(overrun), 16'(m_ovr));
  end

  task automatic apply_stimulus_addr(input logic [7:0] b);
    @(negedge clk); cpu_addr_wr = 1; cpu_wdata = b;
    @(negedge clk); cpu_addr_wr = 0;
  endtask

  task automatic apply_stimulus_write(input logic [7:0] d, output logic we_seen,
                                      output logic [15:0] a_seen, output logic [7:0] d_seen);
    @(negedge clk); cpu_data_wr = 1; cpu_wdata = d;
    @(negedge clk); cpu_data_wr = 0;
    @(negedge clk); we_seen = vram_we; a_seen = vram_addr; d_seen = vram_wdata;
    @(negedge clk);
  endtask

  task automatic apply_stimulus_read(output logic [7:0] rd_at_pulse);
    @(negedge clk); cpu_data_rd = 1; rd_at_pulse = cpu_rdata;
    @(negedge clk); cpu_data_rd = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic        we_s;
    logic [15:0] a_s;
    logic [7:0]  d_s, r_s;
    int          we_count;
    for (int i = 0; i < 16384; i++) begin
      d_s = 8'($urandom);
      vram[i] = d_s;
      mvram[i] = d_s;
    end
    repeat (3) @(negedge clk);
    #1;
    check_output("reset_busy", 16'(busy), 16'h0);
    check_output("reset_rdata", 16'(cpu_rdata), 16'h00);
    reset = 1;

    // Write to 0x2305, then the following write lands at 0x2306.
    apply_stimulus_addr(8'h23);
    apply_stimulus_addr(8'h05);
    apply_stimulus_write(8'hAB, we_s, a_s, d_s);
    check_output("wr_we", 16'(we_s), 16'h1);
    check_output("wr_addr", a_s, 16'h2305);
    check_output("wr_data", 16'(d_s), 16'hAB);
    check_output("wr_we_once", 16'(vram_we), 16'h0);
    apply_stimulus_write(8'hCD, we_s, a_s, d_s);
    check_output("wr_addr_inc", a_s, 16'h2306);

    // Buffered read: old buffer, then 0x11, then 0x22 left in the buffer.
    apply_stimulus_addr(8'h20);
    apply_stimulus_addr(8'h00);
    apply_stimulus_write(8'h11, we_s, a_s, d_s);
    apply_stimulus_write(8'h22, we_s, a_s, d_s);
    apply_stimulus_addr(8'h20);
    apply_stimulus_addr(8'h00);
    apply_stimulus_read(r_s);
    check_output("rd1_old", 16'(r_s), 16'h00);
    apply_stimulus_read(r_s);
    check_output("rd2_first", 16'(r_s), 16'h11);
    check_output("rd_buf", 16'(cpu_rdata), 16'h22);

    // Render hold: write waits on scanline 100, issues once scanline 240 is seen.
    render_en = 1; scanline = 10'd100;
    @(negedge clk); cpu_data_wr = 1; cpu_wdata = 8'h5A;
    @(negedge clk); cpu_data_wr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); render_addr = 16'h0BC0 + 16'(i); #1;
      check_output("hold_busy", 16'(busy), 16'h1);
      check_output("hold_we", 16'(vram_we), 16'h0);
      check_output("hold_addr", vram_addr, 16'h0BC0 + 16'(i));
    end
    @(negedge clk); scanline = 10'd240;
    @(negedge clk); #1;
    check_output("hold_issue_we", 16'(vram_we), 16'h1);
    check_output("hold_issue_addr", vram_addr, 16'h2002);
    check_output("hold_issue_data", 16'(vram_wdata), 16'h5A);
    @(negedge clk); render_en = 0; scanline = 10'd0;

    // 14-bit wrap with the +32 step.
    apply_stimulus_addr(8'h3F);
    apply_stimulus_addr(8'hF0);
    inc32 = 1;
    apply_stimulus_write(8'hE1, we_s, a_s, d_s);
    check_output("wrap_first", a_s, 16'h3FF0);
    inc32 = 0;
    apply_stimulus_write(8'hE2, we_s, a_s, d_s);
    check_output("wrap_addr", a_s, 16'h0010);

    // Overrun: second write during the hold is dropped.
    render_en = 1; scanline = 10'd10;
    @(negedge clk); cpu_data_wr = 1; cpu_wdata = 8'h77;
    @(negedge clk); cpu_wdata = 8'h88;
    @(negedge clk); cpu_data_wr = 0; #1;
    check_output("ovr_flag", 16'(overrun), 16'h1);
    scanline = 10'd241;
    we_count = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (vram_we) begin
        we_count++;
        check_output("ovr_data", 16'(vram_wdata), 16'h77);
      end
    end
    check_output("ovr_we_count", 16'(we_count), 16'd1);
    render_en = 0;

    // Reset during the hold abandons the write and clears the byte toggle.
    render_en = 1; scanline = 10'd50;
    apply_stimulus_addr(8'h3A);
    @(negedge clk); cpu_data_wr = 1; cpu_wdata = 8'h99;
    @(negedge clk); cpu_data_wr = 0; #1;
    check_output("rst_pre_busy", 16'(busy), 16'h1);
    reset = 0; #1;
    check_output("rst_busy", 16'(busy), 16'h0);
    check_output("rst_ovr", 16'(overrun), 16'h0);
    @(negedge clk); reset = 1; render_en = 0;
    we_count = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (vram_we) we_count++;
    end
    check_output("rst_no_we", 16'(we_count), 16'd0);
    apply_stimulus_addr(8'h12);
    apply_stimulus_addr(8'h34);
    apply_stimulus_write(8'h42, we_s, a_s, d_s);
    check_output("rst_toggle", a_s, 16'h1234);

    // Random traffic, with one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) reset = 0;
      else if (i == 1501) reset = 1;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: scanline = 10'($urandom_range(0, 239));
          1: scanline = 10'($urandom_range(240, 260));
          2: scanline = 10'd261;
          default: scanline = 10'($urandom_range(262, 1023));
        endcase
      end
      if ($urandom_range(0, 15) == 0) render_en = 1'($urandom_range(0, 1));
      render_addr = 16'($urandom);
      cpu_wdata   = 8'($urandom);
      inc32       = ($urandom_range(0, 3) == 0);
      cpu_addr_wr = ($urandom_range(0, 7) == 0);
      cpu_data_wr = ($urandom_range(0, 5) == 0);
      cpu_data_rd = ($urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    cpu_addr_wr = 0; cpu_data_wr = 0; cpu_data_rd = 0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ppu_vram_arb.md
PPU_VRAM_ARB -- requirements
Module: ppu_vram_arb

Interface
REQ-001 The parameter VIS_LINES SHALL default to 240 and SHALL give the number of visible scanlines (0..VIS_LINES-1).
REQ-002 The parameter PRE_LINE SHALL default to 261 and SHALL give the pre-render scanline number.
REQ-003 Port clk SHALL be an input, 1 bit: the PPU clock; all state advances on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port render_en SHALL be an input, 1 bit: background or sprite rendering enabled.
REQ-006 Port scanline SHALL be an input, 10 bits: current scanline.
REQ-007 Port render_addr SHALL be an input, 16 bits: VRAM address from the scanline renderer.
REQ-008 Port cpu_addr_wr SHALL be an input, 1 bit: one-cycle pulse marking a CPU write to the address register.
REQ-009 Port cpu_data_wr SHALL be an input, 1 bit: one-cycle pulse marking a CPU write to the data register.
REQ-010 Port cpu_data_rd SHALL be an input, 1 bit: one-cycle pulse marking a CPU read of the data register.
REQ-011 Port cpu_wdata SHALL be an input, 8 bits: CPU write data.
REQ-012 Port inc32 SHALL be an input, 1 bit: address increment select (0 = +1, 1 = +32).
REQ-013 Port vram_rdata SHALL be an input, 8 bits: VRAM read data, valid one cycle after the address is presented.
REQ-014 Port vram_addr SHALL be an output, 16 bits: muxed VRAM address.
REQ-015 Port vram_we SHALL be an output, 1 bit: one-cycle VRAM write strobe.
REQ-016 Port vram_wdata SHALL be an output, 8 bits: VRAM write data.
REQ-017 Port cpu_rdata SHALL be an output, 8 bits: data-register read value (the read buffer).
REQ-018 Port busy SHALL be an output, 1 bit: a CPU access is pending or in flight.
REQ-019 Port overrun SHALL be an output, 1 bit: sticky flag, set when a CPU access is dropped.

Function
REQ-020 rendering SHALL equal render_en AND (scanline < VIS_LINES OR scanline == PRE_LINE).
REQ-021 Address latch: a write toggle w SHALL start at 0; cpu_addr_wr with w=0 SHALL load addr[13:8] from cpu_wdata[5:0] and set w=1; with w=1 it SHALL load addr[7:0] from cpu_wdata and clear w; addr[15:14] SHALL always be 0.
REQ-022 The FSM SHALL have the states IDLE, PEND, ACCESS and CAPTURE.
REQ-023 IDLE -> PEND on cpu_data_rd or cpu_data_wr; the block SHALL latch the op, cpu_wdata and the current addr as acc_addr.
REQ-024 PEND SHALL hold while rendering=1 and SHALL go to ACCESS on the first cycle with rendering=0.
REQ-025 ACCESS SHALL drive vram_addr=acc_addr; for a write it SHALL assert vram_we=1 with vram_wdata=latched data and return to IDLE; for a read it SHALL go to CAPTURE.
REQ-026 CAPTURE SHALL load the read buffer from vram_rdata and return to IDLE.
REQ-027 On leaving ACCESS, addr SHALL become addr + (inc32 ? 32 : 1) modulo 2^14, unless a cpu_addr_wr occurs in the same cycle, which wins.
REQ-028 In every state other than ACCESS, vram_addr SHALL equal render_addr and vram_we SHALL be 0.
REQ-029 busy SHALL be 1 in PEND, ACCESS and CAPTURE.
REQ-030 A cpu_data_rd or cpu_data_wr while busy=1 SHALL be dropped and SHALL set overrun; overrun SHALL clear only on reset.
REQ-031 cpu_addr_wr SHALL be accepted in any state; an access already latched SHALL use its captured acc_addr.
REQ-032 cpu_rdata SHALL always present the read buffer, so a read returns the previously fetched byte (one-deep buffered read).
REQ-033 If rendering rises while the FSM is in ACCESS or CAPTURE, the access SHALL complete; render_addr is overridden for at most 1 cycle.

Reset
REQ-034 reset low SHALL asynchronously force: FSM=IDLE, w=0, addr=0, acc_addr=0, read buffer=0x00, overrun=0, vram_we=0, busy=0, vram_wdata=0x00.
REQ-035 Reset in mid-PEND or mid-ACCESS SHALL abandon the access with no write issued after reset asserts.

Structure
REQ-036 The FSM state enum and the increment constants (INC1=1, INC32=32) SHALL live in the shared package ppu_pkg.
REQ-037 The address latch, write toggle and incrementer SHALL be one sub-module, ppu_vaddr_reg; the FSM, mux and read buffer SHALL stay in the top.

Verification
REQ-038 Write-address test: rendering=0; cpu_addr_wr 0x23 then 0x05; cpu_data_wr 0xAB -> vram_we for 1 cycle at vram_addr=0x2305, data=0xAB; addr then 0x2306.
REQ-039 Buffered-read test: VRAM[0x2000]=0x11 and [0x2001]=0x22, addr=0x2000, inc32=0; two reads -> cpu_rdata returns old buffer, then 0x11; after the second capture buffer=0x22.
REQ-040 Render-hold test: scanline=100, render_en=1, cpu_data_wr -> busy=1 and vram_addr tracks render_addr; scanline->240 -> write issued the next cycle.
REQ-041 Wrap/inc32 test: addr=0x3FF0, inc32=1, one write -> addr=0x0010.
REQ-042 Overrun test: second cpu_data_wr while in PEND -> dropped, overrun=1, only one vram_we observed.
REQ-043 Reset test: reset low during PEND -> busy=0 immediately, no vram_we after release, w=0.
